// File: rtl/touch_gesture_decoder_if.sv
// -----------------------------------------------------------------------------
// touch_gesture_decoder_if
//   Event port of the touch gesture decoder.
//
//   Handshake: the master raises evt_valid with evt_code/evt_pad and keeps all
//   three stable until a cycle where evt_valid && evt_ready is seen on a rising
//   clk edge; that edge is the transfer. evt_ready may be driven freely by the
//   slave and never depends combinationally on evt_valid.
//
//   Signals
//     evt_valid  master->slave  event register holds an event
//     evt_ready  slave->master  consumer accepts the event this cycle
//     evt_code   master->slave  001 TAP, 010 LONG, 100 SLIDE_UP, 101 SLIDE_DOWN,
//                               000 when idle
//     evt_pad    master->slave  pad index (TAP/LONG) or final pad (SLIDE)
// -----------------------------------------------------------------------------
interface touch_gesture_decoder_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_code;
    logic [1:0] evt_pad;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_pad,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_pad,
        output evt_ready
    );
endinterface

// File: rtl/touch_gesture_decoder.sv
// -----------------------------------------------------------------------------
// touch_gesture_decoder
//   Turns three raw capacitive-touch levels into discrete events: per-pad
//   debounce, TAP/LONG classification, optional SLIDE_UP/SLIDE_DOWN detection
//   across pads 0-1-2, and a one-entry event register on a valid/ready port.
//
//   Optional feature macro: TOUCH_SLIDE_EN
//     defined   -> slide FSM and window timer are built, codes 100/101 occur
//     undefined -> only TAP/LONG are produced, SLIDE_WINDOW is unused
//
//   Ports
//     clk          in   clock
//     reset        in   asynchronous active-high reset
//     btn_raw[2:0] in   raw touch levels, bit i = pad i, synchronous to clk
//     evt          if   event port (master modport of touch_gesture_decoder_if)
//     pad_state    out  debounced pad levels
//     ovf          out  sticky flag: an event was dropped
//     ovf_clr      in   clears ovf; a drop in the same cycle wins
//     slide_state  out  current slide FSM state (0 = IDLE; always 0 when the
//                       slide feature is not built)
// -----------------------------------------------------------------------------
module touch_gesture_decoder #(
    parameter int DEB_CYCLES   = 8,
    parameter int LONG_CYCLES  = 1024,
    parameter int SLIDE_WINDOW = 256
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [2:0]                     btn_raw,
    touch_gesture_decoder_if.master        evt,
    output logic [2:0]                     pad_state,
    output logic                           ovf,
    input  logic                           ovf_clr,
    output logic [2:0]                     slide_state
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int LW = $clog2(LONG_CYCLES + 1);

    localparam logic [2:0] CODE_TAP   = 3'b001;
    localparam logic [2:0] CODE_LONG  = 3'b010;
    localparam logic [2:0] CODE_UP    = 3'b100;
    localparam logic [2:0] CODE_DOWN  = 3'b101;

    // ---------------------------------------------------------------- state
    logic [DW-1:0] deb_cnt_q [3];
    logic [DW-1:0] deb_cnt_d [3];
    logic [2:0]    pad_state_q, pad_state_d;
    logic [2:0]    pad_prev_q;
    logic [LW-1:0] timer_q [3];
    logic [LW-1:0] timer_d [3];
    logic          evt_valid_q, evt_valid_d;
    logic [2:0]    evt_code_q, evt_code_d;
    logic [1:0]    evt_pad_q, evt_pad_d;
    logic          ovf_q, ovf_d;

    // Edge pulses of the debounced levels, one cycle after the pad_state edge.
    logic [2:0] onset;
    logic [2:0] rel;
    logic [2:0] long_cand;
    logic [2:0] tap_cand;
    logic       slide_up;
    logic       slide_dn;

    assign onset = pad_state_q & ~pad_prev_q;
    assign rel   = ~pad_state_q & pad_prev_q;

    // ------------------------------------------------- debounce + press timer
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            pad_state_d[i] = pad_state_q[i];
            deb_cnt_d[i]   = '0;
            if (btn_raw[i] != pad_state_q[i]) begin
                // This sample is the DEB_CYCLES-th consecutive difference.
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    pad_state_d[i] = btn_raw[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
                end
            end

            timer_d[i] = '0;
            if (pad_state_q[i]) begin
                if (timer_q[i] < LW'(LONG_CYCLES)) begin
                    timer_d[i] = timer_q[i] + LW'(1);
                end else begin
                    timer_d[i] = timer_q[i];
                end
            end

            // LONG loads on the same edge the timer reaches LONG_CYCLES.
            long_cand[i] = pad_state_q[i] && (timer_q[i] == LW'(LONG_CYCLES - 1));
            // The timer still holds the press length in the release cycle.
            tap_cand[i]  = rel[i] && (timer_q[i] < LW'(LONG_CYCLES));
        end
    end

    // -------------------------------------------------------------- slide FSM
`ifdef TOUCH_SLIDE_EN
    localparam int WW = $clog2(SLIDE_WINDOW + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FWD1 = 3'd1,
        S_FWD2 = 3'd2,
        S_REV1 = 3'd3,
        S_REV2 = 3'd4
    } slide_e;

    slide_e        slide_q, slide_d;
    logic [WW-1:0] win_q, win_d;
    logic          multi_onset;

    assign multi_onset = (onset[0] & onset[1]) | (onset[0] & onset[2]) |
                         (onset[1] & onset[2]);

    always_comb begin
        slide_d  = slide_q;
        win_d    = win_q;
        slide_up = 1'b0;
        slide_dn = 1'b0;
        if (|onset) begin
            win_d = '0;
            if (multi_onset) begin
                slide_d = S_IDLE;
            end else begin
                // Default: re-enter through the IDLE rule for this pad.
                if (onset[0]) begin
                    slide_d = S_FWD1;
                end else if (onset[2]) begin
                    slide_d = S_REV1;
                end else begin
                    slide_d = S_IDLE;
                end
                case (slide_q)
                    S_FWD1: if (onset[1]) slide_d = S_FWD2;
                    S_FWD2: if (onset[2]) begin
                        slide_d  = S_IDLE;
                        slide_up = 1'b1;
                    end
                    S_REV1: if (onset[1]) slide_d = S_REV2;
                    S_REV2: if (onset[0]) begin
                        slide_d  = S_IDLE;
                        slide_dn = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if (slide_q != S_IDLE) begin
            // win_q counts cycles since the last onset; the SLIDE_WINDOW-th
            // quiet cycle abandons the slide.
            if (win_q == WW'(SLIDE_WINDOW - 1)) begin
                slide_d = S_IDLE;
                win_d   = '0;
            end else begin
                win_d = win_q + WW'(1);
            end
        end
    end

    assign slide_state = slide_q;
`else
    // SLIDE_WINDOW has no meaning without the slide FSM.
    logic [31:0] slide_window_unused;
    assign slide_window_unused = SLIDE_WINDOW;
    assign slide_up    = 1'b0;
    assign slide_dn    = 1'b0;
    assign slide_state = 3'd0;
`endif

    // ------------------------------------------------ arbitration + event reg
    logic [2:0] cand_cnt;
    logic [2:0] win_code;
    logic [1:0] win_pad;
    logic       load_ok;
    logic       drop;

    always_comb begin
        cand_cnt = {2'b00, slide_up} + {2'b00, slide_dn};
        for (int i = 0; i < 3; i++) begin
            cand_cnt = cand_cnt + {2'b00, long_cand[i]} + {2'b00, tap_cand[i]};
        end

        // Priority SLIDE > LONG > TAP, then lower pad index (the descending
        // loops leave the lowest asserted pad as the final assignment).
        win_code = 3'd0;
        win_pad  = 2'd0;
        if (slide_up) begin
            win_code = CODE_UP;
            win_pad  = 2'd2;
        end else if (slide_dn) begin
            win_code = CODE_DOWN;
            win_pad  = 2'd0;
        end else if (|long_cand) begin
            win_code = CODE_LONG;
            for (int i = 2; i >= 0; i--) begin
                if (long_cand[i]) win_pad = 2'(i);
            end
        end else if (|tap_cand) begin
            win_code = CODE_TAP;
            for (int i = 2; i >= 0; i--) begin
                if (tap_cand[i]) win_pad = 2'(i);
            end
        end

        load_ok     = !evt_valid_q || evt.evt_ready;
        drop        = 1'b0;
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        evt_pad_d   = evt_pad_q;
        if (evt_valid_q && evt.evt_ready) begin
            evt_valid_d = 1'b0;
            evt_code_d  = 3'd0;
            evt_pad_d   = 2'd0;
        end
        if (cand_cnt != 3'd0) begin
            if (load_ok) begin
                evt_valid_d = 1'b1;
                evt_code_d  = win_code;
                evt_pad_d   = win_pad;
                drop        = (cand_cnt > 3'd1);
            end else begin
                drop = 1'b1;
            end
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // --------------------------------------------------------------- flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= '0;
                timer_q[i]   <= '0;
            end
            pad_state_q <= '0;
            pad_prev_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= 3'd0;
            evt_pad_q   <= 2'd0;
            ovf_q       <= 1'b0;
`ifdef TOUCH_SLIDE_EN
            slide_q     <= S_IDLE;
            win_q       <= '0;
`endif
        end else begin
            for (int i = 0; i < 3; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
                timer_q[i]   <= timer_d[i];
            end
            pad_state_q <= pad_state_d;
            pad_prev_q  <= pad_state_q;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            evt_pad_q   <= evt_pad_d;
            ovf_q       <= ovf_d;
`ifdef TOUCH_SLIDE_EN
            slide_q     <= slide_d;
            win_q       <= win_d;
`endif
        end
    end

    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_code  = evt_code_q;
    assign evt.evt_pad   = evt_pad_q;
    assign pad_state     = pad_state_q;
    assign ovf           = ovf_q;

endmodule
